// File: rtl/paeth_sched_pkg.sv
// Shared types for the paeth call sequencer.
// State encoding, index width and result FIFO entry layout.
package paeth_sched_pkg;

    localparam int IDX_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } sched_state_t;

    typedef struct packed {
        logic [IDX_W-1:0] data;
        logic             last;
    } fifo_entry_t;

endpackage

// File: rtl/paeth_sched_fifo.sv
// In-order result FIFO for the paeth sequencer.
// Push and pop may coincide even when full.
module paeth_sched_fifo
    import paeth_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   push,
    input  fifo_entry_t            push_data,
    input  logic                   pop,
    output fifo_entry_t            pop_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    fifo_entry_t    mem_q [DEPTH];
    fifo_entry_t    mem_d [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic           do_push;
    logic           do_pop;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Output is forced to zero when empty so stale entries never leak out.
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/paeth_call_sched.sv
// Drives the paeth call/return port over an index range and
// streams the returns out in order through a credited FIFO.
module paeth_call_sched
    import paeth_sched_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [IDX_W-1:0] job_base,
    input  logic [CNT_W-1:0] job_count,
    output logic             job_done,
    output logic             pa_start,
    input  logic             pa_busy,
    output logic [IDX_W-1:0] pa_idx,
    input  logic             pa_done,
    output logic             pa_stall,
    input  logic [IDX_W-1:0] pa_returndata,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [IDX_W-1:0] res_data,
    output logic             res_last,
    output logic             err_spurious
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    sched_state_t     state_q, state_d;
    logic [IDX_W-1:0] next_idx_q, next_idx_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [CNT_W-1:0] ret_left_q, ret_left_d;
    logic [CW-1:0]    inflight_q, inflight_d;
    logic             err_q, err_d;

    logic [CW-1:0]    fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    fifo_entry_t      push_entry;
    fifo_entry_t      head;
    logic [CW:0]      credit_used;
    logic             call_acc;
    logic             ret_acc;
    logic             pop;

    assign credit_used = {1'b0, inflight_q} + {1'b0, fifo_count};

    assign job_ready = (state_q == IDLE);
    assign job_done  = (state_q == DONE);
    assign pa_start  = (state_q == ISSUE) && (remaining_q != '0)
                     && (credit_used < (CW+1)'(FIFO_DEPTH));
    assign pa_idx    = next_idx_q;
    // Credits keep a full FIFO from coexisting with pending returns.
    assign pa_stall  = fifo_full && (inflight_q != '0);

    assign call_acc = pa_start && !pa_busy;
    assign ret_acc  = pa_done && !pa_stall && (inflight_q != '0);

    assign push_entry.data = pa_returndata;
    assign push_entry.last = (ret_left_q == CNT_W'(1));

    assign res_valid    = !fifo_empty;
    assign res_data     = head.data;
    assign res_last     = head.last;
    assign pop          = res_valid && res_ready;
    assign err_spurious = err_q;

    paeth_sched_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .resetn    (resetn),
        .push      (ret_acc),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        next_idx_d  = next_idx_q;
        remaining_d = remaining_q;
        ret_left_d  = ret_left_q;
        inflight_d  = inflight_q;
        err_d       = err_q;

        if (pa_done && (inflight_q == '0)) begin
            err_d = 1'b1;
        end
        if (call_acc) begin
            next_idx_d  = next_idx_q + IDX_W'(1);
            remaining_d = remaining_q - CNT_W'(1);
        end
        if (ret_acc) begin
            ret_left_d = ret_left_q - CNT_W'(1);
        end
        unique case ({call_acc, ret_acc})
            2'b10:   inflight_d = inflight_q + CW'(1);
            2'b01:   inflight_d = inflight_q - CW'(1);
            default: inflight_d = inflight_q;
        endcase

        unique case (state_q)
            IDLE: begin
                if (job_valid) begin
                    next_idx_d  = job_base;
                    remaining_d = job_count;
                    ret_left_d  = job_count;
                    state_d     = (job_count == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (call_acc && (remaining_q == CNT_W'(1))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && head.last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            next_idx_q  <= '0;
            remaining_q <= '0;
            ret_left_q  <= '0;
            inflight_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            next_idx_q  <= next_idx_d;
            remaining_q <= remaining_d;
            ret_left_q  <= ret_left_d;
            inflight_q  <= inflight_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_paeth_call_sched.sv
// Directed bench for paeth_call_sched with a two-cycle paeth
// model returning idx*2.
module tb_paeth_call_sched;

    logic        clock;
    logic        resetn;
    logic        job_valid;
    logic        job_ready;
    logic [31:0] job_base;
    logic [15:0] job_count;
    logic        job_done;
    logic        pa_start;
    logic        pa_busy;
    logic [31:0] pa_idx;
    logic        pa_done;
    logic        pa_stall;
    logic [31:0] pa_returndata;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_last;
    logic        err_spurious;

    int n_vec;
    int n_err;

    logic        m1_v, m2_v;
    logic [31:0] m1_d, m2_d;
    logic        f_done;
    logic [31:0] f_data;

    paeth_call_sched #(
        .FIFO_DEPTH (4),
        .CNT_W      (16)
    ) dut (
        .clock         (clock),
        .resetn        (resetn),
        .job_valid     (job_valid),
        .job_ready     (job_ready),
        .job_base      (job_base),
        .job_count     (job_count),
        .job_done      (job_done),
        .pa_start      (pa_start),
        .pa_busy       (pa_busy),
        .pa_idx        (pa_idx),
        .pa_done       (pa_done),
        .pa_stall      (pa_stall),
        .pa_returndata (pa_returndata),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .res_last      (res_last),
        .err_spurious  (err_spurious)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // paeth model: accepted call in cycle N returns idx*2 in cycle N+2
    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            m1_v <= 1'b0;
            m2_v <= 1'b0;
            m1_d <= '0;
            m2_d <= '0;
        end else begin
            m1_v <= pa_start && !pa_busy;
            m1_d <= pa_idx << 1;
            m2_v <= m1_v;
            m2_d <= m1_d;
        end
    end

    assign pa_done       = m2_v | f_done;
    assign pa_returndata = f_done ? f_data : m2_d;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_job(input logic [31:0] b, input logic [15:0] c);
        job_base  = b;
        job_count = c;
        job_valid = 1'b1;
        tick();
        job_valid = 1'b0;
    endtask

    task automatic get_res(output logic [31:0] d, output logic l,
                           output logic ok);
        ok = 1'b0;
        d  = '0;
        l  = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (res_valid) begin
                d  = res_data;
                l  = res_last;
                ok = 1'b1;
            end
            tick();
        end
    endtask

    task automatic wait_done(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (job_done) ok = 1'b1;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic        l;
        logic        ok;
        int          ncalls;
        logic        stall_seen;

        n_vec     = 0;
        n_err     = 0;
        resetn    = 1'b0;
        job_valid = 1'b0;
        job_base  = '0;
        job_count = '0;
        pa_busy   = 1'b0;
        res_ready = 1'b1;
        f_done    = 1'b0;
        f_data    = '0;
        tick();
        tick();
        chk("rst_job_ready", job_ready, 1);
        chk("rst_job_done", job_done, 0);
        chk("rst_pa_start", pa_start, 0);
        chk("rst_pa_idx", pa_idx, 0);
        chk("rst_pa_stall", pa_stall, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_last", res_last, 0);
        chk("rst_err", err_spurious, 0);
        resetn = 1'b1;
        tick();

        // basic job, exact cycle timing
        start_job(32'd10, 16'd3);
        chk("b_ready_low", job_ready, 0);
        chk("b_start0", pa_start, 1);
        chk("b_idx0", pa_idx, 10);
        tick();
        chk("b_idx1", pa_idx, 11);
        tick();
        chk("b_idx2", pa_idx, 12);
        tick();
        chk("b_start_off", pa_start, 0);
        chk("b_v0", res_valid, 1);
        chk("b_d0", res_data, 20);
        chk("b_l0", res_last, 0);
        tick();
        chk("b_d1", res_data, 22);
        chk("b_l1", res_last, 0);
        tick();
        chk("b_d2", res_data, 24);
        chk("b_l2", res_last, 1);
        tick();
        chk("b_done", job_done, 1);
        chk("b_v_off", res_valid, 0);
        tick();
        chk("b_done_off", job_done, 0);
        chk("b_ready_back", job_ready, 1);

        // call stall on second call
        res_ready = 1'b0;
        start_job(32'd10, 16'd3);
        chk("s_idx0", pa_idx, 10);
        tick();
        pa_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("s_hold_start", pa_start, 1);
            chk("s_hold_idx", pa_idx, 11);
            tick();
        end
        pa_busy = 1'b0;
        chk("s_idx1", pa_idx, 11);
        tick();
        chk("s_idx2", pa_idx, 12);
        tick();
        chk("s_start_off", pa_start, 0);
        res_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            get_res(d, l, ok);
            chk("s_res_ok", ok, 1);
            chk("s_res_data", d, 32'd20 + 32'(2 * k));
            chk("s_res_last", l, (k == 2) ? 1 : 0);
        end
        wait_done(ok);
        chk("s_done", ok, 1);

        // result backpressure with credits
        res_ready  = 1'b0;
        ncalls     = 0;
        stall_seen = 1'b0;
        start_job(32'd20, 16'd8);
        for (int i = 0; i < 10; i++) begin
            if (pa_start && !pa_busy) ncalls++;
            if (pa_stall) stall_seen = 1'b1;
            tick();
        end
        chk("p_calls", ncalls, 4);
        chk("p_stall", stall_seen, 0);
        chk("p_start_off", pa_start, 0);
        chk("p_head_v", res_valid, 1);
        chk("p_head_d", res_data, 40);
        res_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (pa_stall) stall_seen = 1'b1;
            get_res(d, l, ok);
            chk("p_res_ok", ok, 1);
            chk("p_res_data", d, 32'd40 + 32'(2 * k));
            chk("p_res_last", l, (k == 7) ? 1 : 0);
        end
        wait_done(ok);
        chk("p_done", ok, 1);
        chk("p_stall_end", stall_seen, 0);
        tick();

        // zero-count job
        start_job(32'd5, 16'd0);
        chk("z_done", job_done, 1);
        chk("z_start", pa_start, 0);
        chk("z_valid", res_valid, 0);
        tick();
        chk("z_done_off", job_done, 0);
        chk("z_ready", job_ready, 1);
        chk("z_valid2", res_valid, 0);

        // reset during DRAIN with two results buffered
        res_ready = 1'b0;
        start_job(32'd50, 16'd4);
        repeat (4) tick();
        chk("r_drain_start", pa_start, 0);
        chk("r_buf_v", res_valid, 1);
        chk("r_buf_d", res_data, 100);
        resetn = 1'b0;
        #1;
        chk("r_job_ready", job_ready, 1);
        chk("r_job_done", job_done, 0);
        chk("r_pa_start", pa_start, 0);
        chk("r_pa_idx", pa_idx, 0);
        chk("r_res_valid", res_valid, 0);
        chk("r_res_data", res_data, 0);
        chk("r_res_last", res_last, 0);
        tick();
        resetn    = 1'b1;
        res_ready = 1'b1;
        tick();
        start_job(32'd100, 16'd1);
        get_res(d, l, ok);
        chk("r2_ok", ok, 1);
        chk("r2_data", d, 200);
        chk("r2_last", l, 1);
        wait_done(ok);
        chk("r2_done", ok, 1);
        chk("r2_no_more", res_valid, 0);
        chk("r2_ready", job_ready, 1);

        // spurious return in IDLE
        chk("e_pre", err_spurious, 0);
        f_data = 32'hdead;
        f_done = 1'b1;
        tick();
        f_done = 1'b0;
        chk("e_set", err_spurious, 1);
        chk("e_no_push", res_valid, 0);
        repeat (3) tick();
        chk("e_sticky", err_spurious, 1);
        chk("e_no_push2", res_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
